line_buffer_nrow: RTL

LINE_BUFFER_NROW -- requirements
Module: line_buffer_nrow

---
 rtl/line_buffer_nrow.sv | 128 ++++++++++++
 1 files changed

// File: rtl/line_buffer_nrow.sv
// N-row line buffer: ROWS-1 line memories deliver ROWS vertically aligned taps of
// the current column, one clock after the pixel enters, with top-border masking.
module line_buffer_nrow #(
    parameter int DW     = 8,
    parameter int W      = 640,
    parameter int ROWS   = 3,
    parameter int BORDER = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vs,
    input  logic                 de,
    input  logic [DW-1:0]        shiftin,
    output logic [ROWS*DW-1:0]   taps,
    output logic                 taps_de,
    output logic                 taps_vs,
    output logic [10:0]          row_cnt,
    output logic                 err_ovf
);

    localparam int CW = $clog2(W + 1);
    localparam int AW = $clog2(W);
    localparam int VW = 3;

    logic [CW-1:0]              r_col;
    logic [10:0]                r_rows;
    logic                       r_de_d;
    logic                       r_vs_d;
    logic [ROWS-1:0][DW-1:0]    r_taps;
    logic                       r_taps_de;
    logic                       r_taps_vs;
    logic [10:0]                r_row_cnt;
    logic                       r_err;

    // r_mem[k] holds the line that is k+1 rows above the current one
    logic [DW-1:0]              r_mem [ROWS-1][W];

    logic                       w_vs_rise;
    logic                       w_de_fall;
    logic                       w_wr;
    logic                       w_ovf;
    logic [AW-1:0]              w_addr;
    logic [VW-1:0]              w_valid;
    logic [DW-1:0]              w_rep;
    logic [ROWS-1:0][DW-1:0]    w_raw;
    logic [ROWS-1:0][DW-1:0]    w_sel;

    assign w_vs_rise = vs & ~r_vs_d;
    assign w_de_fall = r_de_d & ~de;
    assign w_wr      = de && (r_col < CW'(W));
    assign w_ovf     = de && !(r_col < CW'(W));
    assign w_addr    = w_wr ? AW'(r_col) : '0;
    assign w_valid   = (r_rows < 11'(ROWS - 1)) ? VW'(r_rows) : VW'(ROWS - 1);

    // Rows above the fill level hold stale or previous-frame data and are masked.
    always_comb begin
        w_raw    = '0;
        w_sel    = '0;
        w_raw[0] = shiftin;
        for (int k = 1; k < ROWS; k++)
            w_raw[k] = r_mem[k-1][w_addr];
        w_rep = w_raw[0];
        for (int k = 0; k < ROWS; k++)
            if (VW'(k) == w_valid)
                w_rep = w_raw[k];
        for (int k = 0; k < ROWS; k++) begin
            if (VW'(k) <= w_valid)
                w_sel[k] = w_raw[k];
            else if (BORDER != 0)
                w_sel[k] = w_rep;
            else
                w_sel[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[0][w_addr] <= shiftin;
            for (int k = 1; k < ROWS - 1; k++)
                r_mem[k][w_addr] <= r_mem[k-1][w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_rows    <= '0;
            r_de_d    <= 1'b0;
            r_vs_d    <= 1'b0;
            r_taps    <= '0;
            r_taps_de <= 1'b0;
            r_taps_vs <= 1'b0;
            r_row_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_de_d    <= de;
            r_vs_d    <= vs;
            r_taps_vs <= vs;
            if (w_wr) begin
                r_taps    <= w_sel;
                r_taps_de <= 1'b1;
                r_row_cnt <= r_rows;
            end else begin
                r_taps_de <= 1'b0;
            end
            if (w_ovf)
                r_err <= 1'b1;
            else if (w_vs_rise)
                r_err <= 1'b0;
            if (w_vs_rise || w_de_fall)
                r_col <= '0;
            else if (w_wr)
                r_col <= r_col + CW'(1);
            // frame start wins over end-of-line when both land together
            if (w_vs_rise)
                r_rows <= '0;
            else if (w_de_fall && r_rows != 11'd2047)
                r_rows <= r_rows + 11'd1;
        end
    end

    assign taps    = r_taps;
    assign taps_de = r_taps_de;
    assign taps_vs = r_taps_vs;
    assign row_cnt = r_row_cnt;
    assign err_ovf = r_err;

endmodule
